bldc_run_sequencer: RTL

Run-state sequencer for the BLDC velocity datapath. It replaces the fixed-behaviour control unit and drives the strobes that the datapath consumes:
- encoder-count clear, alignment commutation, controller override, commutation enable, filter pulse and control-loop pulse.

It walks the motor through idle, rotor alignment, open-loop spin-up and closed-loop run. It generates the filter and PI update strobes at fixed divided rates, and latches a fault on an external trip or an encoder stall.

---
 rtl/bldc_run_sequencer.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/bldc_run_sequencer.sv
// Run-state sequencer for the BLDC velocity datapath: IDLE -> ALIGN -> SPINUP -> RUN,
// with divided filter/PI strobes and a latched fault on external trip or encoder stall.
module bldc_run_sequencer #(
  parameter int ALIGN_CYCLES  = 50000,
  parameter int SPINUP_CYCLES = 200000,
  parameter int FILTER_DIV    = 1000,
  parameter int LOOP_DIV      = 10,
  parameter int STALL_CYCLES  = 1000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       stop,
  input  logic       ext_fault,
  input  logic       encoder_change,
  output logic       reset_encoder_count,
  output logic       apply_initial_commutation,
  output logic       controller_override,
  output logic       commutation_enable,
  output logic       filter_pulse,
  output logic       control_loop_pulse,
  output logic [2:0] state_out,
  output logic       stall_fault
);

  localparam int PHASE_MAX = (ALIGN_CYCLES > SPINUP_CYCLES) ? ALIGN_CYCLES : SPINUP_CYCLES;
  localparam int PW = $clog2(PHASE_MAX + 1);
  localparam int FW = $clog2(FILTER_DIV + 1);
  localparam int LW = $clog2(LOOP_DIV + 1);
  localparam int SW = (STALL_CYCLES > 0) ? $clog2(STALL_CYCLES + 1) : 1;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ALIGN  = 3'd1,
    ST_SPINUP = 3'd2,
    ST_RUN    = 3'd3,
    ST_FAULT  = 3'd4
  } state_t;

  state_t        state_reg, state_next;
  logic [PW-1:0] phase_reg, phase_next;
  logic [FW-1:0] fdiv_reg, fdiv_next;
  logic [LW-1:0] loop_reg, loop_next;
  logic [SW-1:0] stall_reg, stall_next, stall_inc;
  logic          rec_reg, rec_next;
  logic          aic_reg, aic_next;
  logic          override_reg, override_next;
  logic          comm_en_reg, comm_en_next;
  logic          filter_reg, filter_next;
  logic          loop_pulse_reg, loop_pulse_next;
  logic          stall_fault_reg, stall_fault_next;
  logic          phase_done, stall_hit, drive_now, drive_next;

  always_comb begin
    state_next       = state_reg;
    phase_next       = '0;
    fdiv_next        = '0;
    loop_next        = '0;
    stall_next       = '0;
    loop_pulse_next  = 1'b0;
    stall_fault_next = stall_fault_reg;

    phase_done = ((state_reg == ST_ALIGN)  && (phase_reg == PW'(ALIGN_CYCLES - 1))) ||
                 ((state_reg == ST_SPINUP) && (phase_reg == PW'(SPINUP_CYCLES - 1)));
    stall_inc  = stall_reg + 1'b1;
    // A coincident encoder_change rescues the motor from a stall trip.
    stall_hit  = (STALL_CYCLES != 0) && (state_reg == ST_RUN) && !encoder_change &&
                 (stall_inc == SW'(STALL_CYCLES));

    unique case (state_reg)
      ST_IDLE: begin
        if (!stop && start) state_next = ST_ALIGN;
      end
      ST_ALIGN, ST_SPINUP, ST_RUN: begin
        if (stop) begin
          state_next = ST_IDLE;
        end else if (ext_fault) begin
          state_next       = ST_FAULT;
          stall_fault_next = 1'b0;
        end else if (stall_hit) begin
          state_next       = ST_FAULT;
          stall_fault_next = 1'b1;
        end else if (phase_done) begin
          state_next = (state_reg == ST_ALIGN) ? ST_SPINUP : ST_RUN;
        end
      end
      ST_FAULT: begin
        if (stop) begin
          state_next       = ST_IDLE;
          stall_fault_next = 1'b0;
        end
      end
      default: state_next = ST_IDLE;
    endcase

    if ((state_next == state_reg) && ((state_reg == ST_ALIGN) || (state_reg == ST_SPINUP)))
      phase_next = phase_reg + 1'b1;

    // The filter prescaler restarts only on SPINUP entry and free-runs into RUN.
    drive_now  = (state_reg == ST_SPINUP) || (state_reg == ST_RUN);
    drive_next = (state_next == ST_SPINUP) || (state_next == ST_RUN);
    if (drive_next && drive_now)
      fdiv_next = (fdiv_reg == FW'(FILTER_DIV - 1)) ? '0 : fdiv_reg + 1'b1;
    filter_next = drive_next && (fdiv_next == FW'(FILTER_DIV - 1));

    if ((state_next == ST_RUN) && (state_reg == ST_RUN)) begin
      loop_next = loop_reg;
      if (filter_reg) begin
        if (loop_reg == LW'(LOOP_DIV - 1)) begin
          loop_next       = '0;
          loop_pulse_next = 1'b1;
        end else begin
          loop_next = loop_reg + 1'b1;
        end
      end
      if (!encoder_change && (STALL_CYCLES != 0))
        stall_next = stall_inc;
    end

    rec_next      = (state_next == ST_ALIGN) && (state_reg != ST_ALIGN);
    aic_next      = (state_next == ST_ALIGN);
    override_next = (state_next == ST_ALIGN) || (state_next == ST_SPINUP);
    comm_en_next  = override_next || (state_next == ST_RUN);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg       <= ST_IDLE;
      phase_reg       <= '0;
      fdiv_reg        <= '0;
      loop_reg        <= '0;
      stall_reg       <= '0;
      rec_reg         <= 1'b0;
      aic_reg         <= 1'b0;
      override_reg    <= 1'b0;
      comm_en_reg     <= 1'b0;
      filter_reg      <= 1'b0;
      loop_pulse_reg  <= 1'b0;
      stall_fault_reg <= 1'b0;
    end else begin
      state_reg       <= state_next;
      phase_reg       <= phase_next;
      fdiv_reg        <= fdiv_next;
      loop_reg        <= loop_next;
      stall_reg       <= stall_next;
      rec_reg         <= rec_next;
      aic_reg         <= aic_next;
      override_reg    <= override_next;
      comm_en_reg     <= comm_en_next;
      filter_reg      <= filter_next;
      loop_pulse_reg  <= loop_pulse_next;
      stall_fault_reg <= stall_fault_next;
    end
  end

  assign reset_encoder_count       = rec_reg;
  assign apply_initial_commutation = aic_reg;
  assign controller_override       = override_reg;
  assign commutation_enable        = comm_en_reg;
  assign filter_pulse              = filter_reg;
  assign control_loop_pulse        = loop_pulse_reg;
  assign state_out                 = state_reg;
  assign stall_fault               = stall_fault_reg;

endmodule
